// File: rtl/pram_arbiter.sv
// Arbiter for the single-port program RAM. It shares the port between instruction fetch
// and the loader/debug requester, and provides a zero-fill sequencer that clears every word.
module pram_arbiter #(
   parameter int AW       = 12,
   parameter int DW       = 16,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_start,
   output logic          clr_busy,
   input  logic          if_req,
   input  logic [AW-1:0] if_adr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_adr,
   input  logic [DW-1:0] ld_wdata,
   output logic          ld_gnt,
   output logic          ld_rvalid,
   output logic [DW-1:0] ld_rdata,
   output logic          ram_cs,
   output logic          ram_we,
   output logic [AW-1:0] ram_adr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);

   localparam int WCW = $clog2(MAX_WAIT + 1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t         state_q, state_d;
   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic [AW-1:0]  clr_adr_q, clr_adr_d;
   logic           if_rvalid_q, if_rvalid_d;
   logic           ld_rvalid_q, ld_rvalid_d;
   logic           fetch_forced;

   always_comb begin
      state_d      = state_q;
      clr_adr_d    = clr_adr_q;
      if_gnt       = 1'b0;
      ld_gnt       = 1'b0;
      ram_cs       = 1'b0;
      ram_we       = 1'b0;
      ram_adr      = '0;
      ram_din      = '0;
      fetch_forced = if_req && (wcnt_q == WCW'(MAX_WAIT));

      case (state_q)
         S_IDLE: begin
            if (clr_start) begin
               state_d   = S_CLEAR;
               clr_adr_d = '0;
            end else if (ld_req && !fetch_forced) begin
               ld_gnt  = 1'b1;
               ram_cs  = 1'b1;
               ram_we  = ld_we;
               ram_adr = ld_adr;
               ram_din = ld_wdata;
            end else if (if_req) begin
               if_gnt  = 1'b1;
               ram_cs  = 1'b1;
               ram_adr = if_adr;
            end
         end
         S_CLEAR: begin
            ram_cs    = 1'b1;
            ram_we    = 1'b1;
            ram_adr   = clr_adr_q;
            clr_adr_d = clr_adr_q + 1'b1;
            if (&clr_adr_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // No RAM access or grant is issued while reset is held, so an aborted clear stops cleanly.
      if (reset) begin
         if_gnt = 1'b0;
         ld_gnt = 1'b0;
         ram_cs = 1'b0;
         ram_we = 1'b0;
      end

      if (if_req && !if_gnt)
         wcnt_d = (wcnt_q == WCW'(MAX_WAIT)) ? wcnt_q : wcnt_q + 1'b1;
      else
         wcnt_d = '0;

      if_rvalid_d = if_gnt;
      ld_rvalid_d = ld_gnt && !ld_we;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wcnt_q      <= '0;
         clr_adr_q   <= '0;
         if_rvalid_q <= 1'b0;
         ld_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         clr_adr_q   <= clr_adr_d;
         if_rvalid_q <= if_rvalid_d;
         ld_rvalid_q <= ld_rvalid_d;
      end
   end

   assign clr_busy  = (state_q == S_CLEAR);
   assign if_rvalid = if_rvalid_q;
   assign ld_rvalid = ld_rvalid_q;
   assign if_rdata  = ram_dout;
   assign ld_rdata  = ram_dout;

endmodule

// File: tb/tb_pram_arbiter.sv
// Bench for pram_arbiter: behavioural RAM, a per-cycle reference model of the arbitration
// rules, directed scenarios with literal expectations, then constrained-random traffic.
module tb_pram_arbiter;

   localparam int AW       = 12;
   localparam int DW       = 16;
   localparam int MAX_WAIT = 4;
   localparam int DEPTH    = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          clr_start;
   logic          clr_busy;
   logic          if_req;
   logic [AW-1:0] if_adr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          ld_req;
   logic          ld_we;
   logic [AW-1:0] ld_adr;
   logic [DW-1:0] ld_wdata;
   logic          ld_gnt;
   logic          ld_rvalid;
   logic [DW-1:0] ld_rdata;
   logic          ram_cs;
   logic          ram_we;
   logic [AW-1:0] ram_adr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout = '0;

   pram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset), .clr_start(clr_start), .clr_busy(clr_busy),
      .if_req(if_req), .if_adr(if_adr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ld_req(ld_req), .ld_we(ld_we), .ld_adr(ld_adr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din),
      .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // Behavioural single-port synchronous RAM
   logic [DW-1:0] ram_mem [DEPTH];
   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_we) ram_mem[ram_adr] <= ram_din;
         else        ram_dout         <= ram_mem[ram_adr];
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: expected RAM contents, clear progress, fetch-denial streak, pending reads
   logic [DW-1:0] exp_mem   [DEPTH];
   bit            exp_known [DEPTH];
   int            clear_left = 0;
   int            clr_ptr    = 0;
   int            streak     = 0;
   bit            pend_if = 0, pend_ld = 0, pend_if_k = 0, pend_ld_k = 0;
   logic [DW-1:0] pend_if_d = '0, pend_ld_d = '0;
   bit            e_if_gnt = 0, e_ld_gnt = 0;
   bit            e_cs, e_we, din_care;
   logic [AW-1:0] e_adr;
   logic [DW-1:0] e_din;

   always @(negedge clk) begin
      if (reset) begin
         if (clear_left > 0) exp_known[clr_ptr] = 1'b0;
         if (ld_req && ld_we) exp_known[ld_adr] = 1'b0;
         clear_left = 0;
         streak     = 0;
         pend_if    = 1'b0;
         pend_ld    = 1'b0;
         e_if_gnt   = 1'b0;
         e_ld_gnt   = 1'b0;
      end else begin
         e_if_gnt = 1'b0; e_ld_gnt = 1'b0;
         e_cs = 1'b0; e_we = 1'b0; e_adr = '0; e_din = '0; din_care = 1'b1;
         if (clear_left > 0) begin
            e_cs = 1'b1; e_we = 1'b1; e_adr = AW'(clr_ptr);
         end else if (!clr_start) begin
            if (ld_req && !(if_req && streak >= MAX_WAIT)) begin
               e_ld_gnt = 1'b1; e_cs = 1'b1; e_we = ld_we; e_adr = ld_adr; e_din = ld_wdata;
            end else if (if_req) begin
               e_if_gnt = 1'b1; e_cs = 1'b1; e_adr = if_adr; din_care = 1'b0;
            end
         end

         chk("clr_busy", 32'(clr_busy), 32'(clear_left > 0));
         chk("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
         chk("ld_gnt", 32'(ld_gnt), 32'(e_ld_gnt));
         chk("ram_cs", 32'(ram_cs), 32'(e_cs));
         chk("ram_we", 32'(ram_we), 32'(e_we));
         chk("ram_adr", 32'(ram_adr), 32'(e_adr));
         if (din_care) chk("ram_din", 32'(ram_din), 32'(e_din));
         chk("if_rvalid", 32'(if_rvalid), 32'(pend_if));
         chk("ld_rvalid", 32'(ld_rvalid), 32'(pend_ld));
         if (pend_if && pend_if_k) chk("if_rdata", 32'(if_rdata), 32'(pend_if_d));
         if (pend_ld && pend_ld_k) chk("ld_rdata", 32'(ld_rdata), 32'(pend_ld_d));

         pend_if = e_if_gnt;
         if (e_if_gnt) begin
            pend_if_d = exp_mem[if_adr]; pend_if_k = exp_known[if_adr];
         end
         pend_ld = e_ld_gnt && !ld_we;
         if (pend_ld) begin
            pend_ld_d = exp_mem[ld_adr]; pend_ld_k = exp_known[ld_adr];
         end
         if (e_ld_gnt && ld_we) begin
            exp_mem[ld_adr] = ld_wdata; exp_known[ld_adr] = 1'b1;
         end
         if (if_req && !e_if_gnt) streak = (streak >= MAX_WAIT) ? MAX_WAIT : streak + 1;
         else                     streak = 0;
         if (clear_left > 0) begin
            exp_mem[clr_ptr] = '0; exp_known[clr_ptr] = 1'b1;
            clr_ptr++; clear_left--;
         end else if (clr_start) begin
            clear_left = DEPTH; clr_ptr = 0;
         end
      end
   end

   // Driver: one call = one clock cycle of inputs; returns just after the compare edge
   task automatic cyc(input logic r, input logic c, input logic ir, input logic [AW-1:0] ia,
                      input logic lr, input logic lw, input logic [AW-1:0] la,
                      input logic [DW-1:0] lwd);
      @(posedge clk);
      #1;
      reset = r; clr_start = c; if_req = ir; if_adr = ia;
      ld_req = lr; ld_we = lw; ld_adr = la; ld_wdata = lwd;
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
   endtask
   task automatic ld_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, a, d);
   endtask
   task automatic ld_rd(input logic [AW-1:0] a);
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, a, '0);
   endtask
   task automatic fetch(input logic [AW-1:0] a);
      cyc(1'b0, 1'b0, 1'b1, a, 1'b0, 1'b0, '0, '0);
   endtask

   function automatic logic [AW-1:0] pick();
      if ($urandom_range(0, 7) == 0) return AW'($urandom_range(0, DEPTH - 1));
      return AW'($urandom_range(0, 15));
   endfunction

   int busy, gnts;
   logic          r_ir, r_lr, r_lw, r_c, r_r;
   logic [AW-1:0] r_ia, r_la;
   logic [DW-1:0] r_ld;

   initial begin
      reset = 1'b1; clr_start = 1'b0; if_req = 1'b0; if_adr = '0;
      ld_req = 1'b0; ld_we = 1'b0; ld_adr = '0; ld_wdata = '0;
      repeat (3) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
      idle();
      chk("rst_clr_busy", 32'(clr_busy), 32'd0);
      chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
      chk("rst_ram_cs", 32'(ram_cs), 32'd0);
      chk("rst_gnt", 32'({if_gnt, ld_gnt}), 32'd0);

      // Loader write then read-back
      ld_wr(12'h123, 16'hBEEF);
      chk("t1_wr_gnt", 32'(ld_gnt), 32'd1);
      chk("t1_wr_we", 32'(ram_we), 32'd1);
      ld_rd(12'h123);
      chk("t1_rd_gnt", 32'(ld_gnt), 32'd1);
      idle();
      chk("t1_rvalid", 32'(ld_rvalid), 32'd1);
      chk("t1_rdata", 32'(ld_rdata), 32'h0000BEEF);

      // Back-to-back fetches return data in address order
      for (int i = 0; i < 4; i++) ld_wr(AW'(i), DW'(16'h1110 + i));
      for (int k = 0; k < 5; k++) begin
         if (k < 4) fetch(AW'(k)); else idle();
         if (k < 4) chk("t2_if_gnt", 32'(if_gnt), 32'd1);
         if (k > 0) begin
            chk("t2_if_rvalid", 32'(if_rvalid), 32'd1);
            chk("t2_if_rdata", 32'(if_rdata), 32'(16'h1110 + k - 1));
         end
      end
      idle();
      chk("t2_rvalid_off", 32'(if_rvalid), 32'd0);

      // Starvation guard: loader wins MAX_WAIT cycles, then fetch takes one
      for (int k = 0; k < 10; k++) begin
         cyc(1'b0, 1'b0, 1'b1, 12'h002, 1'b1, 1'b0, 12'h001, '0);
         chk("t3_if_gnt", 32'(if_gnt), 32'((k % 5) == 4));
         chk("t3_ld_gnt", 32'(ld_gnt), 32'((k % 5) != 4));
      end
      idle();

      // Full clear with fetch pending
      ld_wr(12'h000, 16'hFFFF);
      ld_wr(12'hFFF, 16'hFFFF);
      cyc(1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, '0, '0);
      chk("t4_start_gnt", 32'(if_gnt), 32'd0);
      chk("t4_start_cs", 32'(ram_cs), 32'd0);
      busy = 0; gnts = 0;
      for (int n = 0; n < DEPTH + 50; n++) begin
         fetch(12'h000);
         if (!clr_busy) break;
         busy++;
         gnts += int'(if_gnt) + int'(ld_gnt);
      end
      chk("t4_busy_cycles", 32'(busy), 32'd4096);
      chk("t4_grants_in_clear", 32'(gnts), 32'd0);
      chk("t4_gnt_after", 32'(if_gnt), 32'd1);
      fetch(12'hFFF);
      chk("t4_rvalid0", 32'(if_rvalid), 32'd1);
      chk("t4_rdata0", 32'(if_rdata), 32'd0);
      idle();
      chk("t4_rvalidfff", 32'(if_rvalid), 32'd1);
      chk("t4_rdatafff", 32'(if_rdata), 32'd0);

      // Reset partway through a clear
      ld_wr(12'h0FF, 16'h5A5A);
      ld_wr(12'h000, 16'h7777);
      cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
      repeat (99) idle();
      chk("t5_busy_before", 32'(clr_busy), 32'd1);
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
      idle();
      chk("t5_busy_after", 32'(clr_busy), 32'd0);
      ld_rd(12'h000);
      chk("t5_rd_gnt", 32'(ld_gnt), 32'd1);
      ld_rd(12'h0FF);
      chk("t5_rdata0", 32'(ld_rdata), 32'd0);
      idle();
      chk("t5_rvalid_ff", 32'(ld_rvalid), 32'd1);
      chk("t5_rdata_ff", 32'(ld_rdata), 32'h00005A5A);

      // clr_start beats a loader write; the held write lands right after the clear
      cyc(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1, 12'h010, 16'hDEAD);
      chk("t6_start_gnt", 32'(ld_gnt), 32'd0);
      chk("t6_start_cs", 32'(ram_cs), 32'd0);
      busy = 0;
      for (int n = 0; n < DEPTH + 50; n++) begin
         cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 12'h010, 16'hDEAD);
         if (!clr_busy) break;
         busy++;
      end
      chk("t6_busy_cycles", 32'(busy), 32'd4096);
      chk("t6_gnt_after", 32'(ld_gnt), 32'd1);
      ld_rd(12'h011);
      ld_rd(12'h010);
      chk("t6_rdata11", 32'(ld_rdata), 32'd0);
      idle();
      chk("t6_rdata10", 32'(ld_rdata), 32'h0000DEAD);

      // Random traffic; an ungranted requester holds its request
      r_ir = 1'b0; r_lr = 1'b0; r_lw = 1'b0; r_ia = '0; r_la = '0; r_ld = '0;
      for (int n = 0; n < 3000; n++) begin
         if (!(r_ir && !e_if_gnt)) begin
            r_ir = 1'($urandom_range(0, 1)); r_ia = pick();
         end
         if (!(r_lr && !e_ld_gnt)) begin
            r_lr = 1'($urandom_range(0, 1)); r_lw = 1'($urandom_range(0, 1));
            r_la = pick(); r_ld = DW'($urandom_range(0, 16'hFFFF));
         end
         r_c = ($urandom_range(0, 999) == 0);
         r_r = ($urandom_range(0, 1499) == 0);
         cyc(r_r, r_c, r_ir, r_ia, r_lr, r_lw, r_la, r_ld);
      end
      repeat (3) idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
